multichannel_accumulator_serializer: RTL

MULTICHANNEL_ACCUMULATOR_SERIALIZER -- requirements
Module: multichannel_accumulator_serializer

---
 rtl/multichannel_accumulator_serializer_pkg.sv | 14 +
 rtl/multichannel_accumulator_serializer_acc_channel.sv | 36 +++
 rtl/multichannel_accumulator_serializer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/multichannel_accumulator_serializer_pkg.sv
// Shared types for the multichannel accumulator / serializer slice.
// Holds the serializer state encoding and the parameter sanity check.
package multichannel_accumulator_serializer_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } ser_state_e;

    function automatic bit params_ok(input int acc_width, input int window_log2);
        return (acc_width >= 1) && (window_log2 >= 1);
    endfunction

endpackage

// File: rtl/multichannel_accumulator_serializer_acc_channel.sv
// One channel: saturating ones-counter whose snapshot output is the
// count including the current sample, ready to be captured at window end.
module acc_channel
    import multichannel_accumulator_serializer_pkg::*;
#(
    parameter int ACC_WIDTH = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 data_i,
    output logic [ACC_WIDTH-1:0] snap_o
);

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;
    logic [ACC_WIDTH-1:0] sum;

    always_comb begin
        sum   = (acc_q == ACC_MAX) ? ACC_MAX : acc_q + ACC_WIDTH'(data_i);
        acc_d = clear_i ? '0 : sum;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign snap_o = sum;

endmodule

// File: rtl/multichannel_accumulator_serializer.sv
// Per-channel windowed ones-counting with a frame serializer that ships
// each window's counts out channel 0 first, MSB first.
module multichannel_accumulator_serializer
    import multichannel_accumulator_serializer_pkg::*;
#(
    parameter int NUM_CH      = 5,
    parameter int ACC_WIDTH   = 12,
    parameter int WINDOW_LOG2 = 8
) (
    input  logic              accumulatorClk,
    input  logic              accumulatorReset,
    input  logic              enable,
    input  logic              singleShot,
    input  logic [NUM_CH-1:0] dataIn,
    output logic              serialStart,
    output logic              serialOut,
    output logic              serialValid,
    output logic              windowDone,
    output logic              overrun
);

    localparam int FRAME_BITS = NUM_CH * ACC_WIDTH;
    localparam int BCNT_W     = $clog2(FRAME_BITS + 1);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(FRAME_BITS - 1);

    if (!params_ok(ACC_WIDTH, WINDOW_LOG2) || NUM_CH < 1) begin : g_bad_params
        $error("multichannel_accumulator_serializer: illegal parameters");
    end

    logic [WINDOW_LOG2-1:0] cnt_q;
    logic [WINDOW_LOG2-1:0] cnt_d;
    logic                   halted_q;
    logic                   halted_d;
    logic                   count_en;
    logic                   win_end;
    logic                   acc_clear;

    // halted_q blocks single-shot re-arming until enable is seen low
    assign count_en  = enable && !(singleShot && halted_q);
    assign win_end   = !accumulatorReset && count_en && (&cnt_q);
    assign acc_clear = !count_en || win_end;

    always_comb begin
        cnt_d    = cnt_q + WINDOW_LOG2'(1);
        halted_d = halted_q;
        if (acc_clear) begin
            cnt_d = '0;
        end
        if (!enable) begin
            halted_d = 1'b0;
        end else if (win_end && singleShot) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge accumulatorClk) begin
        if (accumulatorReset) begin
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
        end
    end

    logic [ACC_WIDTH-1:0]  snap [NUM_CH];
    logic [FRAME_BITS-1:0] frame_vec;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        acc_channel #(
            .ACC_WIDTH(ACC_WIDTH)
        ) u_acc (
            .clk_i  (accumulatorClk),
            .rst_i  (accumulatorReset),
            .clear_i(acc_clear),
            .data_i (dataIn[g]),
            .snap_o (snap[g])
        );
        assign frame_vec[FRAME_BITS-1-g*ACC_WIDTH -: ACC_WIDTH] = snap[g];
    end

    ser_state_e            state_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [BCNT_W-1:0]     bit_q;
    logic                  start_q;
    logic                  overrun_q;

    // Shifting in zeros leaves shift_q empty once a frame has drained
    always_ff @(posedge accumulatorClk) begin
        if (accumulatorReset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_q     <= '0;
            start_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (win_end) begin
                        shift_q <= frame_vec;
                        bit_q   <= '0;
                        start_q <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shift_q <= shift_q << 1;
                    bit_q   <= bit_q + BCNT_W'(1);
                    if (win_end) begin
                        overrun_q <= 1'b1;
                    end
                    if (bit_q == LAST_BIT) begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign serialValid = (state_q == S_SHIFT);
    assign serialOut   = serialValid && shift_q[FRAME_BITS-1];
    assign serialStart = start_q;
    assign windowDone  = win_end;
    assign overrun     = overrun_q;

endmodule
